// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction fetch slice.
//   OPC_J          : primary opcode of the J-type jump
//   fetch_state_t  : fetch controller states
//   PCSEL_*        : {PCSrc, Branch} encodings for the PC mux
//   fetch_entry_t  : one buffered fetch result {pc, instr}
//   is_j / j_target: predecode helpers for the J-type jump
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam logic [5:0] OPC_J = 6'h02;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_t;

   // {PCSrc, Branch}
   localparam logic [1:0] PCSEL_INC = 2'b00;   // next pc = pc + 1
   localparam logic [1:0] PCSEL_REL = 2'b01;   // next pc = pc + 1 + pc_offset
   localparam logic [1:0] PCSEL_JMP = 2'b10;   // next pc = pc_jmp

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic is_j(input logic [31:0] word);
      return word[31:26] == OPC_J;
   endfunction

   // Jump target keeps the top 6 bits of the jump's own word address.
   function automatic logic [31:0] j_target(input logic [31:0] pc_of_j,
                                            input logic [31:0] word);
      return {pc_of_j[31:26], word[25:0]};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of fetch_entry_t between the fetch controller and decode.
// Storage is reset, so the head outputs read zero out of reset.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   push_i           : write {push_pc_i, push_instr_i} (never issued when full)
//   push_pc_i        : address of the word being written
//   push_instr_i     : instruction word being written
//   pop_i            : remove head (ignored when empty)
//   flush_i          : empty the queue; wins over push and pop
//   head_pc_o        : address of head entry
//   head_instr_o     : head instruction word
//   valid_o          : queue non-empty
//   count_o          : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_queue
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [31:0]              push_pc_i,
   input  logic [31:0]              push_instr_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [31:0]              head_pc_o,
   output logic [31:0]              head_instr_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t [DEPTH-1:0] mem_q;
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     pop_eff;
   fetch_entry_t             push_entry;

   assign pop_eff    = pop_i && (count_q != '0);
   assign push_entry = '{pc: push_pc_i, instr: push_instr_i};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i)  wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_eff) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_i, pop_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_pc_o    = mem_q[rd_ptr_q].pc;
   assign head_instr_o = mem_q[rd_ptr_q].instr;
   assign valid_o      = (count_q != '0);
   assign count_o      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch controller sitting after the PC register. Issues one word read at a
// time from pc, buffers returned words toward decode and steers the PC mux.
// The PC register has no enable: hold is a jump to the current pc.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   pc                        : current PC (word address)
//   PCSrc, Branch             : PC mux select {PCSrc, Branch}
//   pc_offset                 : relative offset, next pc = pc + 1 + pc_offset
//   pc_jmp                    : absolute next pc when {PCSrc,Branch} = 10
//   imem_req/addr/gnt         : instruction memory request channel
//   imem_rvalid/rdata         : instruction memory response channel
//   instr_valid/ready         : head of queue toward decode
//   instr, instr_pc           : head instruction and its address
//   br_valid/taken/pc/offset  : branch resolution from execute
//   perf_stall_cnt            : stall cycles (FETCH_PERF_EN, else 0)
//   perf_redirect_cnt         : taken branches + J redirects (FETCH_PERF_EN,
//                               else 0)
//
// Handshakes: a memory request is accepted in a cycle where imem_req and
// imem_gnt are both high; at most one read is outstanding and its data returns
// in a later cycle with imem_rvalid. A queue entry moves to decode in a cycle
// where instr_valid and instr_ready are both high; instr/instr_pc stay stable
// while instr_valid is high and instr_ready is low.
//
// Optional build macro: FETCH_PERF_EN enables the saturating perf counters.
// -----------------------------------------------------------------------------
module instr_fetch
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        PCSrc,
   output logic        Branch,
   output logic [31:0] pc_offset,
   output logic [31:0] pc_jmp,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_offset,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_redirect_cnt
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state_q, state_d;
   logic [31:0]   req_pc_q, req_pc_d;     // address of the outstanding read
   logic [1:0]    pcsel;
   logic          br_take;
   logic [31:0]   br_target;
   logic          q_push, q_pop, q_flush, q_valid, q_has_room;
   logic [CW-1:0] q_count;

   // A branch resolved while booting is ignored; the pc is not yet valid.
   assign br_take    = br_valid && br_taken && (state_q != S_BOOT);
   assign br_target  = br_pc + 32'd1 + br_offset;
   assign q_has_room = (q_count < CW'(DEPTH));
   assign q_pop      = q_valid && instr_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_BOOT;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_pc_d  = req_pc_q;
      pcsel     = PCSEL_JMP;     // default is hold: jump to the current pc
      pc_jmp    = pc;
      pc_offset = '0;
      imem_req  = 1'b0;
      imem_addr = pc;
      q_push    = 1'b0;
      q_flush   = 1'b0;

      case (state_q)
         S_BOOT: begin
            pc_jmp  = RESET_PC;
            state_d = S_REQ;
         end
         S_REQ: begin
            imem_req = q_has_room;
            if (q_has_room && imem_gnt) begin
               pcsel    = PCSEL_INC;
               req_pc_d = pc;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               q_push  = 1'b1;
               state_d = S_REQ;
               // Predecoded J redirects now; the J itself still goes to decode.
               if (is_j(imem_rdata)) pc_jmp = j_target(req_pc_q, imem_rdata);
            end
         end
         S_DRAIN: begin
            // Response to a read issued on the wrong path: drop it.
            if (imem_rvalid) state_d = S_REQ;
         end
         default: state_d = S_BOOT;
      endcase

      // Taken branch overrides everything above.
      if (br_take) begin
         pcsel     = PCSEL_REL;
         pc_offset = br_target - pc - 32'd1;
         pc_jmp    = pc;
         q_flush   = 1'b1;
         q_push    = 1'b0;
         if (state_q == S_REQ && q_has_room && imem_gnt) begin
            state_d = S_DRAIN;                  // read just issued is stale
         end else if (state_q == S_WAIT && !imem_rvalid) begin
            state_d = S_DRAIN;                  // stale read still in flight
         end
      end
   end

   assign PCSrc  = pcsel[1];
   assign Branch = pcsel[0];

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .push_i       (q_push),
      .push_pc_i    (req_pc_q),
      .push_instr_i (imem_rdata),
      .pop_i        (q_pop),
      .flush_i      (q_flush),
      .head_pc_o    (instr_pc),
      .head_instr_o (instr),
      .valid_o      (q_valid),
      .count_o      (q_count)
   );

   assign instr_valid = q_valid;

`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] redir_cnt_q, redir_cnt_d;
   logic        stall_ev, j_redirect, redir_ev;

   assign stall_ev   = (state_q == S_REQ && !imem_req) ||
                       (state_q == S_WAIT) || (state_q == S_DRAIN);
   assign j_redirect = (state_q == S_WAIT) && imem_rvalid &&
                       is_j(imem_rdata) && !br_take;
   assign redir_ev   = br_take || j_redirect;

   assign stall_cnt_d = (stall_ev && stall_cnt_q != '1) ? stall_cnt_q + 32'd1
                                                        : stall_cnt_q;
   assign redir_cnt_d = (redir_ev && redir_cnt_q != '1) ? redir_cnt_q + 32'd1
                                                        : redir_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign perf_stall_cnt    = stall_cnt_q;
   assign perf_redirect_cnt = redir_cnt_q;
`else
   assign perf_stall_cnt    = '0;
   assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Bench for instr_fetch. The bench owns the PC register and a one-outstanding
// instruction memory. The reference is a program-flow model: the stream seen
// by decode must follow pc -> pc+1, J -> its target, taken branch -> target,
// and each delivered word must equal the memory image at its address.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DUT signals
   logic [31:0] pc = 32'h0000_1234;
   logic        PCSrc, Branch;
   logic [31:0] pc_offset, pc_jmp;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr, instr_pc;
   logic        br_valid = 1'b0, br_taken = 1'b0;
   logic [31:0] br_pc = '0, br_offset = '0;
   logic [31:0] perf_stall_cnt, perf_redirect_cnt;

   instr_fetch #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .pc                (pc),
      .PCSrc             (PCSrc),
      .Branch            (Branch),
      .pc_offset         (pc_offset),
      .pc_jmp            (pc_jmp),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_gnt          (imem_gnt),
      .imem_rvalid       (imem_rvalid),
      .imem_rdata        (imem_rdata),
      .instr_valid       (instr_valid),
      .instr_ready       (instr_ready),
      .instr             (instr),
      .instr_pc          (instr_pc),
      .br_valid          (br_valid),
      .br_taken          (br_taken),
      .br_pc             (br_pc),
      .br_offset         (br_offset),
      .perf_stall_cnt    (perf_stall_cnt),
      .perf_redirect_cnt (perf_redirect_cnt)
   );

   // PC register (no enable, driven only by the mux controls)
   always @(posedge clk) begin
      case ({PCSrc, Branch})
         2'b00:   pc <= pc + 32'd1;
         2'b01:   pc <= pc + 32'd1 + pc_offset;
         default: pc <= pc_jmp;
      endcase
   end

   // Instruction memory: one outstanding read, latency lat_max (+random)
   logic [31:0] mem [256];
   logic        gnt_en    = 1'b1;
   logic        lat_rand  = 1'b0;
   int          lat_max   = 0;
   logic        mem_pend  = 1'b0;
   logic [31:0] mem_addr_q = '0;
   int          mem_delay = 0;

   assign imem_gnt    = imem_req && !mem_pend && gnt_en;
   assign imem_rvalid = mem_pend && (mem_delay == 0);
   assign imem_rdata  = imem_rvalid ? mem[mem_addr_q[7:0]] : 32'h0;

   always @(posedge clk) begin
      if (imem_req && imem_gnt) begin
         mem_pend   <= 1'b1;
         mem_addr_q <= imem_addr;
         mem_delay  <= lat_rand ? int'($urandom_range(lat_max, 0)) : lat_max;
      end else if (imem_rvalid) begin
         mem_pend <= 1'b0;
      end else if (mem_pend && mem_delay > 0) begin
         mem_delay <= mem_delay - 1;
      end
   end

   // scoreboard state
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_next = RESET_PC;
   int          n_deliv = 0;
   int          since_rst = 0;
   int          first_valid = -1;
   logic        j_check_en = 1'b0;
   int          j_seen = 0;
   logic        watch_en = 1'b0;
   logic [31:0] watch_addr = '0;
   logic        no6_en = 1'b0;
   logic        saw6 = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle. Called just after a negedge with inputs already driven.
   task automatic step();
      logic        br_now, jchk;
      logic [31:0] tgt, jt, w;
      #1;
      chk("pcsel_legal", {31'b0, PCSrc & Branch}, 32'h0);
      if (instr_valid && first_valid < 0) first_valid = since_rst;
      if (instr_valid && instr_ready) begin
         chk("deliv_pc", instr_pc, exp_next);
         chk("deliv_instr", instr, mem[exp_next[7:0]]);
         if (exp_q.size() > 0) chk("deliv_order", instr_pc, exp_q.pop_front());
         w = mem[exp_next[7:0]];
         exp_next = (w[31:26] == 6'h02) ? {exp_next[31:26], w[25:0]} : exp_next + 32'd1;
         n_deliv++;
      end
      if (watch_en && imem_req && imem_gnt) begin
         chk("first_addr", imem_addr, watch_addr);
         watch_en = 1'b0;
      end
      if (no6_en && imem_req && imem_gnt && imem_addr == 32'd6) saw6 = 1'b1;
      br_now = br_valid && br_taken && !rst && since_rst >= 1;
      tgt = br_pc + 32'd1 + br_offset;
      if (br_now) begin
         chk("br_branch", {31'b0, Branch}, 32'd1);
         chk("br_pcsrc", {31'b0, PCSrc}, 32'd0);
         chk("br_offset", pc_offset, tgt - pc - 32'd1);
         exp_next = tgt;
      end
      jchk = j_check_en && !br_now && imem_rvalid && (imem_rdata[31:26] == 6'h02);
      jt = {mem_addr_q[31:26], imem_rdata[25:0]};
      @(posedge clk);
      @(negedge clk);
      if (!rst) since_rst++;
      if (br_now) chk("br_pc_next", pc, tgt);
      if (jchk) begin
         chk("j_pc_next", pc, jt);
         j_seen++;
      end
   endtask

   task automatic reset_checks(input string tag);
      #1;
      chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
      chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
      chk({tag, "_instr"}, instr, 32'd0);
      chk({tag, "_instr_pc"}, instr_pc, 32'd0);
      chk({tag, "_pcsrc"}, {31'b0, PCSrc}, 32'd1);
      chk({tag, "_branch"}, {31'b0, Branch}, 32'd0);
      chk({tag, "_pc_jmp"}, pc_jmp, RESET_PC);
      chk({tag, "_pc_offset"}, pc_offset, 32'd0);
      chk({tag, "_perf_stall"}, perf_stall_cnt, 32'd0);
      chk({tag, "_perf_redir"}, perf_redirect_cnt, 32'd0);
   endtask

   task automatic release_reset();
      rst       = 1'b0;
      since_rst = 0;
      exp_next  = RESET_PC;
   endtask

   initial begin
      logic [31:0] w;
      int base;
      logic found;

      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         if (w[31:26] == 6'h02) w[31:26] = 6'h23;
         mem[i] = w;
      end
      mem[5] = 32'h0800_0040;   // J 0x40

      // ---- T1: reset values, boot, in-order delivery 0,1,2 ----
      @(negedge clk);
      reset_checks("rst");
      repeat (2) @(negedge clk);
      release_reset();
      #1;
      chk("boot_pcsrc", {31'b0, PCSrc}, 32'd1);
      chk("boot_branch", {31'b0, Branch}, 32'd0);
      chk("boot_pc_jmp", pc_jmp, RESET_PC);
      chk("boot_req", {31'b0, imem_req}, 32'd0);
      instr_ready = 1'b1;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd2);
      for (int c = 0; c < 30 && n_deliv < 3; c++) step();
      chk("t1_delivered", n_deliv, 32'd3);
      chk("t1_latency_ge3", {31'b0, first_valid >= 3}, 32'd1);

      // ---- T2: decode stalls, queue fills, pc frozen ----
      instr_ready = 1'b0;
      repeat (8) step();
      #1;
      chk("t2_req_off", {31'b0, imem_req}, 32'd0);
      chk("t2_valid", {31'b0, instr_valid}, 32'd1);
      chk("t2_head_pc", instr_pc, 32'd3);
      chk("t2_pc", pc, 32'd5);
      chk("t2_hold_pcsrc", {31'b0, PCSrc}, 32'd1);
      chk("t2_hold_branch", {31'b0, Branch}, 32'd0);
      chk("t2_hold_pc_jmp", pc_jmp, pc);

      // ---- T3: resume; J at 5 redirects to 0x40, addr 6 never fetched ----
      instr_ready = 1'b1;
      j_check_en  = 1'b1;
      no6_en      = 1'b1;
      watch_en    = 1'b1;
      watch_addr  = 32'd5;
      for (int c = 0; c < 40 && n_deliv < 9; c++) step();
      chk("t3_delivered", n_deliv, 32'd9);
      chk("t3_j_seen", j_seen, 32'd1);
      chk("t3_no_addr6", {31'b0, saw6}, 32'd0);
      chk("t3_watch_done", {31'b0, watch_en}, 32'd0);
      j_check_en = 1'b0;
      no6_en     = 1'b0;

      // ---- T4: taken branch while a read is in flight ----
      instr_ready = 1'b0;
      lat_max     = 2;
      found       = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         step();
         #1;
         found = mem_pend && !imem_rvalid && instr_valid;
      end
      chk("t4_found_wait", {31'b0, found}, 32'd1);
      br_valid  = 1'b1;
      br_taken  = 1'b1;
      br_pc     = 32'd8;
      br_offset = 32'hFFFF_FFFC;
      watch_en  = 1'b1;
      watch_addr = 32'd5;
      step();
      br_valid = 1'b0;
      br_taken = 1'b0;
      #1;
      chk("t4_flushed", {31'b0, instr_valid}, 32'd0);
      instr_ready = 1'b1;
      base = n_deliv;
      for (int c = 0; c < 60 && n_deliv < base + 3; c++) step();
      chk("t4_delivered", n_deliv - base, 32'd3);
      chk("t4_watch_done", {31'b0, watch_en}, 32'd0);

      // ---- T5: branch target wraps to 0 ----
      lat_max = 0;
      repeat (3) step();
      br_valid  = 1'b1;
      br_taken  = 1'b1;
      br_pc     = 32'd0;
      br_offset = 32'hFFFF_FFFF;
      step();
      br_valid = 1'b0;
      br_taken = 1'b0;
      base = n_deliv;
      for (int c = 0; c < 40 && n_deliv < base + 3; c++) step();
      chk("t5_delivered", n_deliv - base, 32'd3);

      // ---- T6: reset while a read is outstanding ----
      lat_max = 3;
      repeat (6) step();
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         step();
         #1;
         found = mem_pend && !imem_rvalid;
      end
      chk("t6_found_wait", {31'b0, found}, 32'd1);
      rst = 1'b1;
      reset_checks("t6_rst");
      step();
      release_reset();
      base = n_deliv;
      for (int c = 0; c < 60 && n_deliv < base + 3; c++) step();
      chk("t6_delivered", n_deliv - base, 32'd3);

      // ---- T7: randomized traffic with J words in the image ----
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(9, 0) == 0) mem[i] = {6'h02, 18'h0, 8'($urandom)};
      end
      @(negedge clk);
      release_reset();
      lat_rand = 1'b1;
      lat_max  = 2;
      base = n_deliv;
      for (int c = 0; c < 2000; c++) begin
         instr_ready = ($urandom_range(3, 0) != 0);
         gnt_en      = ($urandom_range(3, 0) != 0);
         br_valid    = ($urandom_range(15, 0) == 0);
         br_taken    = ($urandom_range(1, 0) == 1);
         br_pc       = 32'($urandom_range(250, 0));
         br_offset   = 32'($urandom_range(40, 0)) - 32'd20;
         step();
      end
      br_valid    = 1'b0;
      br_taken    = 1'b0;
      gnt_en      = 1'b1;
      instr_ready = 1'b1;
      repeat (20) step();
      chk("t7_progress", {31'b0, (n_deliv - base) > 100}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
